// File: rtl/iovec_pkg.sv
// Shared types and constants for the iovec tristate bus master.
package iovec_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        TURN   = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } iovec_state_e;

    // Cycle counts are parameters of type int; the wait counter only holds CNT_W bits.
    function automatic logic [CNT_W-1:0] to_count(input int cycles);
        return cycles[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/iovec_wait_counter.sv
// Loadable down-counter shared by the DRIVE, TURN and SAMPLE phases.
module iovec_wait_counter
    import iovec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // The owning state leaves on the cycle the count shows 1.
    assign done = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/iovec_bus_master.sv
// Request/response master driving a bidirectional pin vector through an
// external tristate buffer: timed writes with turnaround, delayed-sample reads.
module iovec_bus_master
    import iovec_pkg::*;
#(
    parameter int IOVEC_WIDTH  = 8,
    parameter int WR_CYCLES    = 2,
    parameter int TURNAROUND   = 1,
    parameter int SAMPLE_DELAY = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req__ENA,
    output logic                   req__RDY,
    input  logic                   req_write,
    input  logic [IOVEC_WIDTH-1:0] req_data,
    output logic                   rsp__ENA,
    input  logic                   rsp__RDY,
    output logic [IOVEC_WIDTH-1:0] rsp_data,
    output logic [IOVEC_WIDTH-1:0] pins_I,
    output logic                   pins_T,
    input  logic [IOVEC_WIDTH-1:0] pins_O
);

    localparam logic HAS_TURN = (TURNAROUND != 32'sd0);

    iovec_state_e               state_r;
    iovec_state_e               next_state_s;
    logic                       cnt_load_s;
    logic [CNT_W-1:0]           cnt_value_s;
    logic                       cnt_done_s;
    logic                       accept_s;
    logic                       capture_s;
    logic                       rdy_r;
    logic                       pins_t_r;
    logic                       rsp_ena_r;
    logic [IOVEC_WIDTH-1:0]     pins_i_r;
    logic [IOVEC_WIDTH-1:0]     rsp_data_r;

    // rdy_r is low through reset, so a request can never slip in on the first edge after it.
    assign accept_s  = req__ENA & rdy_r;
    assign capture_s = (state_r == SAMPLE) & cnt_done_s;

    iovec_wait_counter u_wait (
        .clk        (CLK),
        .rst        (RST),
        .load       (cnt_load_s),
        .load_value (cnt_value_s),
        .done       (cnt_done_s)
    );

    // Next-state and counter-load decode.
    always_comb begin
        next_state_s = state_r;
        cnt_load_s   = 1'b0;
        cnt_value_s  = {CNT_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_load_s = 1'b1;
                    if (req_write) begin
                        next_state_s = DRIVE;
                        cnt_value_s  = to_count(WR_CYCLES);
                    end else begin
                        next_state_s = SAMPLE;
                        cnt_value_s  = to_count(SAMPLE_DELAY);
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_done_s) begin
                    if (HAS_TURN) begin
                        next_state_s = TURN;
                        cnt_load_s   = 1'b1;
                        cnt_value_s  = to_count(TURNAROUND);
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = DRIVE;
                end
            end
            TURN: begin
                if (cnt_done_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = TURN;
                end
            end
            SAMPLE: begin
                if (cnt_done_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = SAMPLE;
                end
            end
            RESP: begin
                if (rsp__RDY) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Outputs are registered from the next state so they line up with it exactly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_r      <= 1'b0;
            pins_t_r   <= 1'b1;
            rsp_ena_r  <= 1'b0;
            pins_i_r   <= {IOVEC_WIDTH{1'b0}};
            rsp_data_r <= {IOVEC_WIDTH{1'b0}};
        end else begin
            rdy_r     <= (next_state_s == IDLE);
            pins_t_r  <= (next_state_s != DRIVE);
            rsp_ena_r <= (next_state_s == RESP);
            if (accept_s && req_write) begin
                pins_i_r <= req_data;
            end else begin
                pins_i_r <= pins_i_r;
            end
            if (capture_s) begin
                rsp_data_r <= pins_O;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign req__RDY = rdy_r;
    assign pins_T   = pins_t_r;
    assign pins_I   = pins_i_r;
    assign rsp__ENA = rsp_ena_r;
    assign rsp_data = rsp_data_r;

endmodule

// File: tb/tb_iovec_bus_master.sv
// Bench for iovec_bus_master: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_iovec_bus_master;

    localparam int W   = 8;
    localparam int WR  = 2;
    localparam int TA  = 1;
    localparam int SD  = 2;
    localparam int INF = 32'h7fffffff;

    logic         CLK, RST;
    logic         req__ENA, req__RDY, req_write, rsp__ENA, rsp__RDY, pins_T;
    logic [W-1:0] req_data, rsp_data, pins_I, pins_O;

    // Second instance with zero turnaround for the back-to-back case.
    logic         b_ena, b_rdy, b_write, b_rsp_ena, b_rsp_rdy, b_pins_T;
    logic [W-1:0] b_data, b_rsp_data, b_pins_I, b_pins_O;

    iovec_bus_master #(.IOVEC_WIDTH(W), .WR_CYCLES(WR), .TURNAROUND(TA), .SAMPLE_DELAY(SD)) u_dut (
        .CLK(CLK), .RST(RST), .req__ENA(req__ENA), .req__RDY(req__RDY), .req_write(req_write),
        .req_data(req_data), .rsp__ENA(rsp__ENA), .rsp__RDY(rsp__RDY), .rsp_data(rsp_data),
        .pins_I(pins_I), .pins_T(pins_T), .pins_O(pins_O)
    );

    iovec_bus_master #(.IOVEC_WIDTH(W), .WR_CYCLES(WR), .TURNAROUND(0), .SAMPLE_DELAY(SD)) u_dut0 (
        .CLK(CLK), .RST(RST), .req__ENA(b_ena), .req__RDY(b_rdy), .req_write(b_write),
        .req_data(b_data), .rsp__ENA(b_rsp_ena), .rsp__RDY(b_rsp_rdy), .rsp_data(b_rsp_data),
        .pins_I(b_pins_I), .pins_T(b_pins_T), .pins_O(b_pins_O)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: every operation is a set of cycle-number windows.
    int         cyc = 0;
    int         rdy_from, drive_from, drive_to, rsp_from, cap_cycle;
    bit         pending, take_m, hs_m;
    logic [W-1:0] m_pins_i, m_rsp_data;
    logic       exp_rdy, exp_t, exp_rsp_ena;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_from = 0; drive_from = 0; drive_to = -1;
            rsp_from = INF; cap_cycle = -1; pending = 1'b0;
            m_pins_i = '0; m_rsp_data = '0;
            exp_rdy = 1'b0; exp_t = 1'b1; exp_rsp_ena = 1'b0;
        end else begin
            take_m = exp_rdy && req__ENA;
            hs_m   = exp_rsp_ena && rsp__RDY;
            if (take_m && req_write) begin
                m_pins_i   = req_data;
                drive_from = cyc + 1;
                drive_to   = cyc + WR;
                rdy_from   = cyc + WR + TA + 1;
            end else if (take_m) begin
                pending   = 1'b1;
                cap_cycle = cyc + SD;
                rsp_from  = cyc + SD + 1;
                rdy_from  = INF;
            end
            if (pending && cyc == cap_cycle) m_rsp_data = pins_O;
            if (hs_m) begin
                pending  = 1'b0;
                rdy_from = cyc + 1;
            end
            cyc++;
            exp_rdy     = (cyc >= rdy_from);
            exp_t       = !(cyc >= drive_from && cyc <= drive_to);
            exp_rsp_ena = pending && (cyc >= rsp_from);
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            check("m_req_rdy",  32'(req__RDY), 32'(exp_rdy));
            check("m_pins_T",   32'(pins_T),   32'(exp_t));
            check("m_pins_I",   32'(pins_I),   32'(m_pins_i));
            check("m_rsp_ena",  32'(rsp__ENA), 32'(exp_rsp_ena));
            check("m_rsp_data", 32'(rsp_data), 32'(m_rsp_data));
        end
    end

    logic e35_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic e35_r [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   acc_k, lat;
    bit   got;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; req__ENA = 1'b0; req_write = 1'b0; req_data = '0; rsp__RDY = 1'b0; pins_O = '0;
        b_ena = 1'b0; b_write = 1'b0; b_data = '0; b_rsp_rdy = 1'b1; b_pins_O = 8'h96;
        repeat (3) @(posedge CLK);
        check_en = 1'b1;
        #1;
        check("rst_rdy",      32'(req__RDY), 32'd0);
        check("rst_pins_T",   32'(pins_T),   32'd1);
        check("rst_pins_I",   32'(pins_I),   32'd0);
        check("rst_rsp_ena",  32'(rsp__ENA), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        next_cycle();
        check("rdy_after_rst", 32'(req__RDY), 32'd1);

        // Write 0xA5: two driven cycles, one released, then ready.
        req__ENA = 1'b1; req_write = 1'b1; req_data = 8'hA5;
        next_cycle();
        req__ENA = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("wr_pins_T", 32'(pins_T),   32'(e35_t[k]));
            check("wr_rdy",    32'(req__RDY), 32'(e35_r[k]));
            check("wr_pins_I", 32'(pins_I),   32'hA5);
            if (k < 3) next_cycle();
        end

        // Write 0x5A, then a read request held while busy must be ignored.
        req__ENA = 1'b1; req_write = 1'b1; req_data = 8'h5A;
        next_cycle();
        req_write = 1'b0; req_data = 8'hFF;
        check("busy_t1", 32'(pins_T), 32'd0);
        check("busy_i1", 32'(pins_I), 32'h5A);
        next_cycle();
        check("busy_t2", 32'(pins_T), 32'd0);
        check("busy_i2", 32'(pins_I), 32'h5A);
        next_cycle();
        req__ENA = 1'b0;
        check("busy_t3",   32'(pins_T),   32'd1);
        check("busy_rdy3", 32'(req__RDY), 32'd0);
        next_cycle();
        check("busy_rdy4", 32'(req__RDY), 32'd1);
        check("busy_ena4", 32'(rsp__ENA), 32'd0);
        check("busy_i4",   32'(pins_I),   32'h5A);

        // Read of 0x3C with the consumer stalling for five cycles.
        req__ENA = 1'b1; req_write = 1'b0; pins_O = 8'h3C; rsp__RDY = 1'b0;
        next_cycle();
        req__ENA = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            check("rd_early_ena", 32'(rsp__ENA), 32'd0);
            check("rd_pins_T",    32'(pins_T),   32'd1);
            next_cycle();
        end
        pins_O = 8'hC3;
        for (int k = 0; k < 5; k++) begin
            check("rd_stall_ena",  32'(rsp__ENA), 32'd1);
            check("rd_stall_data", 32'(rsp_data), 32'h3C);
            check("rd_stall_rdy",  32'(req__RDY), 32'd0);
            check("rd_stall_T",    32'(pins_T),   32'd1);
            next_cycle();
        end
        rsp__RDY = 1'b1;
        check("rd_hs_ena", 32'(rsp__ENA), 32'd1);
        next_cycle();
        rsp__RDY = 1'b0;
        check("rd_done_ena",  32'(rsp__ENA), 32'd0);
        check("rd_done_rdy",  32'(req__RDY), 32'd1);
        check("rd_done_data", 32'(rsp_data), 32'h3C);

        // Reset pulse inside the first DRIVE cycle releases the bus at once.
        req__ENA = 1'b1; req_write = 1'b1; req_data = 8'h77;
        next_cycle();
        req__ENA = 1'b0;
        check("pre_rst_T", 32'(pins_T), 32'd0);
        check("pre_rst_I", 32'(pins_I), 32'h77);
        #1 RST = 1'b1;
        #1;
        check("async_rst_T",    32'(pins_T),   32'd1);
        check("async_rst_I",    32'(pins_I),   32'd0);
        check("async_rst_rdy",  32'(req__RDY), 32'd0);
        check("async_rst_ena",  32'(rsp__ENA), 32'd0);
        check("async_rst_data", 32'(rsp_data), 32'd0);
        #1 RST = 1'b0;
        next_cycle();
        check("post_rst_rdy", 32'(req__RDY), 32'd1);
        check("post_rst_T",   32'(pins_T),   32'd1);

        // Zero turnaround: write 0x11 then a read accepted WR+1 cycles later.
        b_ena = 1'b1; b_write = 1'b1; b_data = 8'h11;
        next_cycle();
        b_write = 1'b0;
        acc_k = 0;
        for (int k = 1; k <= 12 && acc_k == 0; k++) begin
            if (k <= WR) begin
                check("b2b_pins_T", 32'(b_pins_T), 32'd0);
                check("b2b_pins_I", 32'(b_pins_I), 32'h11);
            end
            if (b_rdy) acc_k = k;
            next_cycle();
        end
        b_ena = 1'b0;
        check("b2b_accept_cycle", 32'(acc_k), 32'd3);
        check("b2b_rd_T",   32'(b_pins_T), 32'd1);
        check("b2b_rd_rdy", 32'(b_rdy),    32'd0);
        got = 1'b0; lat = -1;
        for (int k = 0; k < 8 && !got; k++) begin
            if (b_rsp_ena) begin
                got = 1'b1; lat = k;
                check("b2b_rsp_data", 32'(b_rsp_data), 32'h96);
            end else begin
                next_cycle();
            end
        end
        check("b2b_rsp_seen", 32'(got), 32'd1);
        check("b2b_rsp_lat",  32'(lat), 32'd2);

        // Random traffic against the model, with occasional async resets.
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            req__ENA  = ($urandom_range(0, 99) < 60);
            req_write = 1'($urandom_range(0, 1));
            req_data  = 8'($urandom);
            pins_O    = 8'($urandom);
            rsp__RDY  = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 79) == 0) begin
                #1 RST = 1'b1;
                #2 RST = 1'b0;
            end
        end
        @(negedge CLK);
        req__ENA = 1'b0; rsp__RDY = 1'b1;
        repeat (12) @(negedge CLK);
        check("final_rdy", 32'(req__RDY), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iovec_bus_master.md
IOVEC_BUS_MASTER -- requirements
Module: iovec_bus_master

Interface
REQ-001 Parameter IOVEC_WIDTH, default 8: width of the bidirectional pin vector and data paths.
REQ-002 Parameter WR_CYCLES, default 2: cycles a write drives the bus; legal range 1..15.
REQ-003 Parameter TURNAROUND, default 1: released-bus cycles after a write before the next op; legal range 0..15.
REQ-004 Parameter SAMPLE_DELAY, default 2: cycles from bus release to capture of pins_O on a read; legal range 1..15.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 req__ENA  input  1  request valid; accepted only when req__RDY is 1.
REQ-008 req__RDY  output  1  module can accept a request this cycle.
REQ-009 req_write  input  1  1 = write, 0 = read; qualified by req__ENA.
REQ-010 req_data  input  IOVEC_WIDTH  write data; ignored for reads.
REQ-011 rsp__ENA  output  1  read response valid.
REQ-012 rsp__RDY  input  1  consumer accepts response this cycle.
REQ-013 rsp_data  output  IOVEC_WIDTH  captured read data; stable while rsp__ENA is 1.
REQ-014 pins_I  output  IOVEC_WIDTH  data to the tristate buffer inputs (client side of IobufVecPins).
REQ-015 pins_T  output  1  tristate control; 1 = bus released, 0 = driven.
REQ-016 pins_O  input  IOVEC_WIDTH  value read back from the pad.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE, TURN, SAMPLE, RESP.
REQ-018 req__RDY SHALL be 1 only in IDLE; a request is accepted on a cycle with req__ENA=1 and req__RDY=1.
REQ-019 An accepted write SHALL register req_data into pins_I, enter DRIVE, and hold pins_T=0 for exactly WR_CYCLES cycles.
REQ-020 After DRIVE, pins_T SHALL return to 1 and the FSM SHALL enter TURN for TURNAROUND cycles, or go directly to IDLE if TURNAROUND=0.
REQ-021 Writes SHALL produce no response; rsp__ENA SHALL remain 0.
REQ-022 An accepted read SHALL keep pins_T=1, enter SAMPLE, and capture pins_O into rsp_data on the SAMPLE_DELAY-th SAMPLE cycle.
REQ-023 After capture the FSM SHALL enter RESP, asserting rsp__ENA=1 from the next cycle onward, and SHALL remain there until rsp__RDY=1.
REQ-024 The cycle with rsp__ENA=1 and rsp__RDY=1 SHALL return the FSM to IDLE, so req__RDY=1 on the following cycle; no request is accepted in the same cycle.
REQ-025 pins_T SHALL be 0 only in DRIVE; in every other state and during reset it SHALL be 1.
REQ-026 pins_I SHALL hold its last driven value when the bus is released.
REQ-027 A single 4-bit down-counter SHALL time DRIVE, TURN and SAMPLE; it is loaded on state entry and the state exits when the count reaches 1.
REQ-028 Read latency from acceptance to rsp__ENA SHALL be SAMPLE_DELAY+1 cycles; write occupancy from acceptance to req__RDY SHALL be WR_CYCLES+TURNAROUND+1 cycles.
REQ-029 rsp__RDY asserted outside RESP SHALL be ignored.

Reset
REQ-030 While RST=1, outputs SHALL be as follows regardless of CLK: state=IDLE, pins_T=1, pins_I=0, rsp__ENA=0, rsp_data=0, and counter=0.
REQ-031 req__RDY SHALL be 0 while RST=1 and SHALL be 1 on the first cycle after RST deasserts.
REQ-032 Reset asserted mid-DRIVE SHALL release the bus (pins_T=1) immediately without waiting for a clock edge; the interrupted operation is discarded.

Structure
REQ-033 A shared package iovec_pkg SHALL hold the state enum type and the counter-width constant (4).
REQ-034 One sub-module, iovec_wait_counter, SHALL implement the loadable 4-bit down-counter with a done flag.

Verification
REQ-035 The bench SHALL cover: write 0xA5, WR_CYCLES=2, TURNAROUND=1 -> pins_T=0 for exactly 2 cycles with pins_I=0xA5, then 1 cycle released, then req__RDY=1.
REQ-036 The bench SHALL cover: read with pins_O=0x3C, SAMPLE_DELAY=2 -> rsp__ENA=1 3 cycles after acceptance, with rsp_data=0x3C and pins_T=1 throughout.
REQ-037 The bench SHALL cover: read response with rsp__RDY held 0 for 5 cycles -> rsp__ENA and rsp_data stable for all 5 cycles, FSM to IDLE after the rsp__RDY=1 cycle, and req__RDY=0 throughout.
REQ-038 The bench SHALL cover: RST pulse during the first DRIVE cycle -> pins_T=1 before the next CLK edge and all outputs at reset values.
REQ-039 The bench SHALL cover: TURNAROUND=0, a back-to-back write 0x11 then a read -> read accepted exactly WR_CYCLES+1 cycles after the write is accepted.
REQ-040 The bench SHALL cover: req__ENA=1 while busy -> request not accepted, pins and FSM unaffected.
